// File: rtl/updown_mod_counter_pkg.sv
// Shared constants for the up/down modulo counter: direction and limit-mode encodings.
package updown_mod_counter_pkg;

    // Direction encoding on up_down
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    // Limit behaviour encoding on sat_mode
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage : updown_mod_counter_pkg

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle of the up/down modulo counter.
// master drives the controls and observes status; slave is the counter itself.
interface updown_mod_counter_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 2
);
    logic              en;
    logic              up_down;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  max_val;
    logic [STEP_W-1:0] step;
    logic              sat_mode;
    logic [WIDTH-1:0]  count;
    logic              ovf;
    logic              unf;
    logic              at_max;
    logic              at_zero;

    modport master (
        output en, up_down, load, load_val, max_val, step, sat_mode,
        input  count, ovf, unf, at_max, at_zero
    );

    modport slave (
        input  en, up_down, load, load_val, max_val, step, sat_mode,
        output count, ovf, unf, at_max, at_zero
    );
endinterface : updown_mod_counter_if

// File: rtl/updown_next_calc.sv
// Combinational next-count evaluation for one enabled edge: range repair,
// up/down stepping with wrap or saturate, and the overflow/underflow pulse request.
module updown_next_calc
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 2
) (
    input  logic [WIDTH-1:0]  count_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic [WIDTH-1:0]  max_val_i,
    input  logic              dir_i,
    input  logic              mode_i,
    output logic [WIDTH-1:0]  count_o,
    output logic              ovf_o,
    output logic              unf_o
);
    // All comparisons and wrap sums are carried in WIDTH+1 bits so that
    // max_val = 2^WIDTH-1 (modulus 2^WIDTH) neither truncates nor aliases.
    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   max_x;
    logic [WIDTH:0]   step_x;
    logic [WIDTH:0]   mod_x;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH-1:0] sum_lo;
    logic [WIDTH-1:0] diff_lo;
    logic [WIDTH-1:0] wrap_up;
    logic [WIDTH-1:0] wrap_dn;

    assign cnt_x   = {1'b0, count_i};
    assign max_x   = {1'b0, max_val_i};
    assign step_x  = (WIDTH+1)'(step_i);
    assign mod_x   = max_x + 1'b1;
    assign sum_x   = cnt_x + step_x;
    assign sum_lo  = WIDTH'(sum_x);
    assign diff_lo = WIDTH'(cnt_x - step_x);
    assign wrap_up = WIDTH'(sum_x - mod_x);
    assign wrap_dn = WIDTH'(cnt_x + mod_x - step_x);

    // Select next count and pulse requests; range repair takes precedence over stepping
    always_comb begin
        count_o = count_i;
        ovf_o   = 1'b0;
        unf_o   = 1'b0;
        if (count_i > max_val_i) begin
            count_o = max_val_i;
        end else if (dir_i == DIR_UP) begin
            if (sum_x > max_x) begin
                ovf_o   = 1'b1;
                count_o = (mode_i == MODE_SAT) ? max_val_i : wrap_up;
            end else begin
                count_o = sum_lo;
            end
        end else begin
            if (cnt_x >= step_x) begin
                count_o = diff_lo;
            end else begin
                unf_o   = 1'b1;
                count_o = (mode_i == MODE_SAT) ? '0 : wrap_dn;
            end
        end
    end

endmodule : updown_next_calc

// File: rtl/updown_mod_counter.sv
// Programmable-modulus up/down counter: holds the count register, applies
// load-over-enable priority, registers ovf/unf pulses and decodes terminal flags.
module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 2
) (
    input  logic clk,
    input  logic rst,
    updown_mod_counter_if.slave bus
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] calc_count;
    logic             calc_ovf;
    logic             calc_unf;

    // Loaded values are clamped into the current range 0..max_val
    function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] val,
                                                      input logic [WIDTH-1:0] lim);
        return (val > lim) ? lim : val;
    endfunction

    updown_next_calc #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next_calc (
        .count_i   (count_q),
        .step_i    (bus.step),
        .max_val_i (bus.max_val),
        .dir_i     (bus.up_down),
        .mode_i    (bus.sat_mode),
        .count_o   (calc_count),
        .ovf_o     (calc_ovf),
        .unf_o     (calc_unf)
    );

    // Next state: load beats enable; pulses only come from an enabled step
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (bus.load) begin
            count_d = clamp_to_max(bus.load_val, bus.max_val);
        end else if (bus.en) begin
            count_d = calc_count;
            ovf_d   = calc_ovf;
            unf_d   = calc_unf;
        end
    end

    // Count and pulse registers, cleared immediately when rst goes low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.ovf     = ovf_q;
    assign bus.unf     = unf_q;
    assign bus.at_max  = (count_q == bus.max_val);
    assign bus.at_zero = (count_q == '0);

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// Directed self-checking bench for updown_mod_counter (WIDTH=4, STEP_W=2).
module tb_updown_mod_counter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    updown_mod_counter_if #(.WIDTH(4), .STEP_W(2)) bus ();

    updown_mod_counter #(.WIDTH(4), .STEP_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.en = 1'b0; bus.load = 1'b0; bus.up_down = 1'b1;
        bus.load_val = 4'd0; bus.step = 2'd1; bus.sat_mode = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] v, input logic [3:0] mx);
        bus.max_val = mx; bus.load_val = v; bus.load = 1'b1; bus.en = 1'b0;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.count !== 4'd0 || bus.ovf !== 1'b0 || bus.unf !== 1'b0 || bus.at_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_init: count=%0d ovf=%b unf=%b at_zero=%b, want 0 0 0 1",
                     bus.count, bus.ovf, bus.unf, bus.at_zero);
        end
        rst = 1'b1;
        do_load(4'd7, 4'd15);
        n_checks++;
        if (bus.count !== 4'd7) begin
            n_fail++; $display("FAIL reset_preload: count=%0d want 7", bus.count);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (bus.count !== 4'd0 || bus.ovf !== 1'b0 || bus.unf !== 1'b0 || bus.at_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: count=%0d ovf=%b unf=%b at_zero=%b, want 0 0 0 1",
                     bus.count, bus.ovf, bus.unf, bus.at_zero);
        end
        #1 rst = 1'b1;
        bus.en = 1'b1; bus.up_down = 1'b1; bus.step = 2'd2;
        tick();
        n_checks++;
        if (bus.count !== 4'd2) begin
            n_fail++; $display("FAIL reset_release_edge: count=%0d want 2", bus.count);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_wrap_up();
        logic [3:0] exp_cnt [10];
        exp_cnt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
        set_idle();
        do_load(4'd0, 4'd9);
        bus.en = 1'b1; bus.step = 2'd1; bus.up_down = 1'b1; bus.sat_mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (bus.count !== exp_cnt[i] || bus.ovf !== (i == 9) || bus.at_max !== (i == 8)) begin
                n_fail++;
                $display("FAIL wrap_up[%0d]: count=%0d ovf=%b at_max=%b, want %0d %b %b",
                         i, bus.count, bus.ovf, bus.at_max, exp_cnt[i], (i == 9), (i == 8));
            end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_sat_up();
        logic       exp_ovf [3];
        exp_ovf = '{1'b0, 1'b1, 1'b1};
        set_idle();
        do_load(4'd12, 4'd15);
        bus.en = 1'b1; bus.step = 2'd3; bus.up_down = 1'b1; bus.sat_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.count !== 4'd15 || bus.ovf !== exp_ovf[i] || bus.at_max !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_up[%0d]: count=%0d ovf=%b at_max=%b, want 15 %b 1",
                         i, bus.count, bus.ovf, bus.at_max, exp_ovf[i]);
            end
        end
        bus.en = 1'b0;
        tick();
        n_checks++;
        if (bus.count !== 4'd15 || bus.ovf !== 1'b0) begin
            n_fail++; $display("FAIL sat_idle: count=%0d ovf=%b, want 15 0", bus.count, bus.ovf);
        end
    endtask

    task automatic test_wrap_down();
        logic [3:0] exp_cnt [4];
        logic       exp_unf [4];
        exp_cnt = '{4'd8, 4'd5, 4'd2, 4'd9};
        exp_unf = '{1'b1, 1'b0, 1'b0, 1'b1};
        set_idle();
        do_load(4'd1, 4'd9);
        bus.en = 1'b1; bus.step = 2'd3; bus.up_down = 1'b0; bus.sat_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (bus.count !== exp_cnt[i] || bus.unf !== exp_unf[i] || bus.ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_down[%0d]: count=%0d unf=%b ovf=%b, want %0d %b 0",
                         i, bus.count, bus.unf, bus.ovf, exp_cnt[i], exp_unf[i]);
            end
        end
        // saturating down from 1 by 3 pins at zero with an underflow pulse
        bus.en = 1'b0;
        do_load(4'd1, 4'd9);
        bus.en = 1'b1; bus.sat_mode = 1'b1;
        tick();
        n_checks++;
        if (bus.count !== 4'd0 || bus.unf !== 1'b1 || bus.at_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_down: count=%0d unf=%b at_zero=%b, want 0 1 1",
                     bus.count, bus.unf, bus.at_zero);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_load_clamp();
        set_idle();
        bus.max_val = 4'd9; bus.load_val = 4'd12; bus.load = 1'b1; bus.en = 1'b1;
        bus.up_down = 1'b1; bus.step = 2'd3;
        tick();
        n_checks++;
        if (bus.count !== 4'd9 || bus.ovf !== 1'b0 || bus.at_max !== 1'b1) begin
            n_fail++;
            $display("FAIL load_clamp: count=%0d ovf=%b at_max=%b, want 9 0 1",
                     bus.count, bus.ovf, bus.at_max);
        end
        bus.load = 1'b0; bus.en = 1'b0;
        tick();
        n_checks++;
        if (bus.count !== 4'd9) begin
            n_fail++; $display("FAIL load_hold: count=%0d want 9", bus.count);
        end
        // step of zero holds with no pulse
        bus.en = 1'b1; bus.step = 2'd0;
        tick();
        n_checks++;
        if (bus.count !== 4'd9 || bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin
            n_fail++;
            $display("FAIL step_zero: count=%0d ovf=%b unf=%b, want 9 0 0", bus.count, bus.ovf, bus.unf);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_full_range_and_repair();
        set_idle();
        do_load(4'd14, 4'd15);
        bus.en = 1'b1; bus.step = 2'd3; bus.up_down = 1'b1; bus.sat_mode = 1'b0;
        tick();
        n_checks++;
        if (bus.count !== 4'd1 || bus.ovf !== 1'b1) begin
            n_fail++; $display("FAIL full_wrap: count=%0d ovf=%b, want 1 1", bus.count, bus.ovf);
        end
        bus.en = 1'b0;
        do_load(4'd9, 4'd15);
        bus.max_val = 4'd5; bus.en = 1'b1; bus.step = 2'd1;
        tick();
        n_checks++;
        if (bus.count !== 4'd5 || bus.ovf !== 1'b0 || bus.unf !== 1'b0 || bus.at_max !== 1'b1) begin
            n_fail++;
            $display("FAIL range_repair: count=%0d ovf=%b unf=%b at_max=%b, want 5 0 0 1",
                     bus.count, bus.ovf, bus.unf, bus.at_max);
        end
        bus.en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        set_idle();
        bus.max_val = 4'd15;
        #12;
        test_reset();
        test_wrap_up();
        test_sat_up();
        test_wrap_down();
        test_load_clamp();
        test_full_range_and_repair();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule : tb_updown_mod_counter
